gray_lbp_host: RTL and testbench
================================

Name: gray_lbp_host

Overview:
- Memory-side responder for the gray-image read and LBP-result write interfaces used by the LBP engine.
- Holds a 128x128 8-bit gray image, loaded over a byte stream, and serves engine reads with fixed 1-cycle latency.
- Captures the engine's LBP result writes into a result memory, tracks completion, and exposes the results on a readback port.

Parameters:
- ADDR_W, 14, address width of both image and result memories (depth 2**ADDR_W).
- DATA_W, 8, pixel and LBP data width.
- IMG_DIM, 128, image row length in pixels; used for border decode only.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- load_valid  in  1  image byte available on load_data
- load_data  in  DATA_W  image byte; raster order, address 0 first
- load_ready  out  1  host accepts a load byte this cycle
- gray_ready  out  1  image loaded; engine may issue reads
- gray_req  in  1  engine read request
- gray_addr  in  ADDR_W  engine read address
- gray_data  out  DATA_W  read data, registered
- lbp_valid  in  1  engine result write strobe
- lbp_addr  in  ADDR_W  result write address
- lbp_data  in  DATA_W  result byte
- finish  in  1  engine completion pulse/level
- done  out  1  result capture complete
- wr_count  out  ADDR_W+1  number of accepted result writes
- rb_addr  in  ADDR_W  result readback address
- rb_data  out  DATA_W  result readback data, registered
- err_border  out  1  sticky border-write flag (see Optional Feature)

Behaviour:
- Reset values:
  - load_ready=0, gray_ready=0, gray_data=0, done=0, wr_count=0, rb_data=0, err_border=0.
  - Load pointer=0; state=LOAD.
  - Memory contents are not cleared.
- FSM LOAD:
  - load_ready=1.
  - On load_valid&load_ready: image[ptr]<=load_data; ptr<=ptr+1.
  - On the write to address 2**ADDR_W-1: ptr wraps to 0; next state SERVE.
  - load_ready and gray_ready are registered: load_ready drops and gray_ready rises on the cycle after the last byte.
- FSM SERVE:
  - gray_ready=1; load_ready=0; load_valid is ignored.
  - gray_req=1 sampled at edge N: gray_data valid after edge N, equal to image[gray_addr sampled at edge N].
  - gray_req=0: gray_data holds its previous value.
  - Back-to-back requests are supported at 1 per cycle; no stall.
  - lbp_valid=1 at an edge: result[lbp_addr]<=lbp_data; wr_count<=wr_count+1, saturating at 2**ADDR_W.
  - Rewrites to the same address overwrite the stored value and still count.
  - finish=1 at an edge: next state DONE.
  - If lbp_valid and finish are high in the same cycle, that write is captured and counted.
- FSM DONE:
  - done=1 and gray_ready=0 from the cycle after finish.
  - gray_req, lbp_valid and load_valid are ignored; gray_data holds.
  - DONE is terminal; only reset leaves it.
- lbp_valid in LOAD is ignored (not written, not counted).
- gray_req in LOAD does not update gray_data.
- Readback is active in all states: rb_data<=result[rb_addr] every cycle, 1-cycle latency.
- Reset mid-operation: immediate return to the reset values and LOAD. The image must be reloaded in full.
- Address arithmetic is unsigned, modulo 2**ADDR_W. Out-of-range addresses cannot occur.

Optional Feature:
- Macro: LBP_BORDER_CHECK_EN.
- Defined:
  - In SERVE, any accepted lbp_valid write whose address falls on the image border sets err_border=1.
  - Border means row=lbp_addr/IMG_DIM equal to 0 or IMG_DIM-1, or col=lbp_addr%IMG_DIM equal to 0 or IMG_DIM-1.
  - err_border is sticky until reset.
  - The write itself is still performed and counted.
- Undefined: no border-decode logic; err_border is tied to 0.

Test Plan:
- Reset, then stream 16384 bytes with image[a]=a[7:0], load_valid held high. Required: load_ready drops and gray_ready=1 on the cycle after byte 16383; load_valid afterwards changes nothing.
- SERVE, gray_req=1 with gray_addr=129,0,130,16383 on consecutive cycles. Required: gray_data = 129,0,130,255, each one cycle later; gray_req=0 then holds 255.
- SERVE, lbp_valid pulses: addr 129 data 0xA5, then addr 130 data 0x3C, then addr 129 data 0x11. Required: wr_count=3; rb_addr=129 gives rb_data=0x11 one cycle later; rb_addr=130 gives 0x3C.
- lbp_valid (addr 200, data 0x7E) and finish asserted in the same cycle. Required: wr_count increments; done=1 and gray_ready=0 next cycle; readback of 200 is 0x7E; later lbp_valid and gray_req are ignored.
- Assert reset while SERVE is halfway through, e.g. after 500 writes. Required: wr_count=0, gray_ready=0, load_ready=1, done=0; a full reload is needed before gray_ready returns.
- With LBP_BORDER_CHECK_EN: write to addr 129 gives err_border=0; write to addr 127 gives err_border=1 and it stays 1 through further writes. Without the macro, both writes leave err_border=0.

Source files
------------

// File: rtl/gray_lbp_host.sv
// gray_lbp_host: image store and LBP result capture responder for the LBP engine.
// Optional border-write detection enabled by defining LBP_BORDER_CHECK_EN.
`default_nettype none

module gray_lbp_host #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8,
  parameter int IMG_DIM = 128
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_valid,
  input  logic [DATA_W-1:0]   load_data,
  output logic                load_ready,
  output logic                gray_ready,
  input  logic                gray_req,
  input  logic [ADDR_W-1:0]   gray_addr,
  output logic [DATA_W-1:0]   gray_data,
  input  logic                lbp_valid,
  input  logic [ADDR_W-1:0]   lbp_addr,
  input  logic [DATA_W-1:0]   lbp_data,
  input  logic                finish,
  output logic                done,
  output logic [ADDR_W:0]     wr_count,
  input  logic [ADDR_W-1:0]   rb_addr,
  output logic [DATA_W-1:0]   rb_data,
  output logic                err_border
);

  localparam int C_DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [DATA_W-1:0] r_image  [C_DEPTH];
  logic [DATA_W-1:0] r_result [C_DEPTH];

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_load_ready;
  logic              r_gray_ready;
  logic              r_done;
  logic [ADDR_W:0]   r_wr_count;
  logic [DATA_W-1:0] r_gray_data;
  logic [DATA_W-1:0] r_rb_data;

  logic w_load_acc;
  logic w_last_byte;
  logic w_gray_rd;
  logic w_lbp_wr;
  logic w_cnt_max;

  assign w_load_acc  = (r_state == S_LOAD) && load_valid && r_load_ready;
  assign w_last_byte = (r_ptr == {ADDR_W{1'b1}});
  assign w_gray_rd   = (r_state == S_SERVE) && gray_req;
  assign w_lbp_wr    = (r_state == S_SERVE) && lbp_valid;
  assign w_cnt_max   = (r_wr_count == {1'b1, {ADDR_W{1'b0}}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_ptr        <= '0;
      r_load_ready <= 1'b0;
      r_gray_ready <= 1'b0;
      r_done       <= 1'b0;
      r_wr_count   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          // load_ready is registered, so it drops on the cycle after the final byte
          r_load_ready <= !(w_load_acc && w_last_byte);
          if (w_load_acc) begin
            r_ptr <= r_ptr + 1'b1;
            if (w_last_byte) begin
              r_state      <= S_SERVE;
              r_gray_ready <= 1'b1;
            end
          end
        end
        S_SERVE: begin
          if (w_lbp_wr && !w_cnt_max) begin
            r_wr_count <= r_wr_count + 1'b1;
          end
          if (finish) begin
            r_state      <= S_DONE;
            r_gray_ready <= 1'b0;
            r_done       <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_acc) begin
      r_image[r_ptr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_lbp_wr) begin
      r_result[lbp_addr] <= lbp_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gray_data <= '0;
    end else if (w_gray_rd) begin
      r_gray_data <= r_image[gray_addr];
    end
  end

  // Readback runs in every state so results stay visible after completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rb_data <= '0;
    end else begin
      r_rb_data <= r_result[rb_addr];
    end
  end

`ifdef LBP_BORDER_CHECK_EN
  logic [ADDR_W-1:0] w_row;
  logic [ADDR_W-1:0] w_col;
  logic              w_border;
  logic              r_err_border;

  assign w_row    = lbp_addr / ADDR_W'(IMG_DIM);
  assign w_col    = lbp_addr % ADDR_W'(IMG_DIM);
  assign w_border = (w_row == '0) || (w_row == ADDR_W'(IMG_DIM - 1)) ||
                    (w_col == '0) || (w_col == ADDR_W'(IMG_DIM - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_border <= 1'b0;
    end else if (w_lbp_wr && w_border) begin
      r_err_border <= 1'b1;
    end
  end

  assign err_border = r_err_border;
`else
  localparam int C_UNUSED_IMG_DIM = IMG_DIM;
  assign err_border = 1'b0;
`endif

  assign load_ready = r_load_ready;
  assign gray_ready = r_gray_ready;
  assign gray_data  = r_gray_data;
  assign done       = r_done;
  assign wr_count   = r_wr_count;
  assign rb_data    = r_rb_data;

endmodule

`default_nettype wire

// File: tb/tb_gray_lbp_host.sv
// tb_gray_lbp_host: directed, table-driven checks of load, serve, capture, done and reset.
`default_nettype none

module tb_gray_lbp_host;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        done;
  logic [14:0] wr_count;
  logic [13:0] rb_addr;
  logic [7:0]  rb_data;
  logic        err_border;

`ifdef LBP_BORDER_CHECK_EN
  localparam logic BC = 1'b1;
`else
  localparam logic BC = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  gray_lbp_host dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .done       (done),
    .wr_count   (wr_count),
    .rb_addr    (rb_addr),
    .rb_data    (rb_data),
    .err_border (err_border)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_image();
    int cnt = 0;
    int cyc = 0;
    load_valid = 1'b1;
    load_data  = 8'd0;
    while (cnt < 16384 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (load_ready) begin
        if (cnt == 16383) chk("gray_ready_before_last", gray_ready, 0);
        @(posedge clk);
        #1;
        cnt++;
        load_data = 8'(cnt);
      end
    end
    chk("load_byte_count", cnt, 16384);
    chk("load_ready_after_last", load_ready, 0);
    chk("gray_ready_after_last", gray_ready, 1);
  endtask

  typedef struct {
    logic        req;
    logic [13:0] ga;
    logic        lv;
    logic [13:0] la;
    logic [7:0]  ld;
    logic [13:0] ra;
    logic [7:0]  eg;
    logic [14:0] ewc;
    logic        crb;
    logic [7:0]  erb;
    logic        eerr;
  } vec_t;

  vec_t vt[14];

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_data = '0; gray_req = 1'b0; gray_addr = '0;
    lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0; rb_addr = '0;

    // req ga lv la ld ra | gray wr_count chk_rb rb err
    vt[0]  = '{1'b1, 14'd129,   1'b0, 14'd0,   8'h00, 14'd0,   8'd129, 15'd0, 1'b0, 8'h00, 1'b0};
    vt[1]  = '{1'b1, 14'd0,     1'b0, 14'd0,   8'h00, 14'd0,   8'd0,   15'd0, 1'b0, 8'h00, 1'b0};
    vt[2]  = '{1'b1, 14'd130,   1'b0, 14'd0,   8'h00, 14'd0,   8'd130, 15'd0, 1'b0, 8'h00, 1'b0};
    vt[3]  = '{1'b1, 14'd16383, 1'b0, 14'd0,   8'h00, 14'd0,   8'd255, 15'd0, 1'b0, 8'h00, 1'b0};
    vt[4]  = '{1'b0, 14'd5,     1'b1, 14'd129, 8'hA5, 14'd0,   8'd255, 15'd1, 1'b0, 8'h00, 1'b0};
    vt[5]  = '{1'b0, 14'd6,     1'b1, 14'd130, 8'h3C, 14'd0,   8'd255, 15'd2, 1'b0, 8'h00, 1'b0};
    vt[6]  = '{1'b0, 14'd7,     1'b1, 14'd129, 8'h11, 14'd0,   8'd255, 15'd3, 1'b0, 8'h00, 1'b0};
    vt[7]  = '{1'b0, 14'd0,     1'b0, 14'd0,   8'h00, 14'd129, 8'd255, 15'd3, 1'b1, 8'h11, 1'b0};
    vt[8]  = '{1'b0, 14'd0,     1'b0, 14'd0,   8'h00, 14'd130, 8'd255, 15'd3, 1'b1, 8'h3C, 1'b0};
    vt[9]  = '{1'b1, 14'd257,   1'b1, 14'd129, 8'h22, 14'd0,   8'd1,   15'd4, 1'b0, 8'h00, 1'b0};
    vt[10] = '{1'b0, 14'd0,     1'b0, 14'd0,   8'h00, 14'd129, 8'd1,   15'd4, 1'b1, 8'h22, 1'b0};
    vt[11] = '{1'b0, 14'd0,     1'b1, 14'd129, 8'h44, 14'd0,   8'd1,   15'd5, 1'b0, 8'h00, 1'b0};
    vt[12] = '{1'b0, 14'd0,     1'b1, 14'd127, 8'h55, 14'd0,   8'd1,   15'd6, 1'b0, 8'h00, BC};
    vt[13] = '{1'b0, 14'd0,     1'b1, 14'd300, 8'h66, 14'd0,   8'd1,   15'd7, 1'b0, 8'h00, BC};

    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load_ready", load_ready, 0);
    chk("rst_gray_ready", gray_ready, 0);
    chk("rst_gray_data", gray_data, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rb_data", rb_data, 0);
    chk("rst_err_border", err_border, 0);
    @(negedge clk);
    reset = 1'b0;

    load_image();
    // Bytes presented after the load completes must not disturb the image
    load_data = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    chk("post_load_ready_low", load_ready, 0);
    load_valid = 1'b0;

    for (int i = 0; i < 14; i++) begin
      gray_req  = vt[i].req;
      gray_addr = vt[i].ga;
      lbp_valid = vt[i].lv;
      lbp_addr  = vt[i].la;
      lbp_data  = vt[i].ld;
      rb_addr   = vt[i].ra;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_gray_data", i), gray_data, vt[i].eg);
      chk($sformatf("vec%0d_wr_count", i), wr_count, vt[i].ewc);
      chk($sformatf("vec%0d_err_border", i), err_border, vt[i].eerr);
      if (vt[i].crb) chk($sformatf("vec%0d_rb_data", i), rb_data, vt[i].erb);
    end

    // Write and finish in the same cycle: write captured, then DONE
    gray_req = 1'b0; lbp_valid = 1'b1; lbp_addr = 14'd200; lbp_data = 8'h7E; finish = 1'b1;
    @(posedge clk);
    #1;
    chk("finish_wr_count", wr_count, 8);
    chk("finish_done", done, 1);
    chk("finish_gray_ready", gray_ready, 0);
    lbp_valid = 1'b0; finish = 1'b0; rb_addr = 14'd200;
    @(posedge clk);
    #1;
    chk("finish_rb_200", rb_data, 8'h7E);
    lbp_valid = 1'b1; lbp_data = 8'h55; gray_req = 1'b1; gray_addr = 14'd129; load_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_ignore_wr_count", wr_count, 8);
    chk("done_ignore_gray", gray_data, 1);
    chk("done_ignore_rb_200", rb_data, 8'h7E);
    chk("done_terminal", done, 1);
    lbp_valid = 1'b0; gray_req = 1'b0; load_valid = 1'b0;

    // Full reload, then reset in the middle of SERVE after 500 writes
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rerun_done_cleared", done, 0);
    load_image();
    load_valid = 1'b0;
    for (int i = 0; i < 500; i++) begin
      lbp_valid = 1'b1; lbp_addr = 14'(1000 + i); lbp_data = 8'(i);
      @(posedge clk);
      #1;
    end
    lbp_valid = 1'b0;
    chk("serve_500_writes", wr_count, 500);
    #3 reset = 1'b1;
    #1;
    chk("midrst_wr_count", wr_count, 0);
    chk("midrst_gray_ready", gray_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_gray_data", gray_data, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_load_ready", load_ready, 1);
    chk("midrst_gray_ready_wait", gray_ready, 0);
    load_image();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
